warp_lsu: RTL

WARP_LSU -- requirements
Module: warp_lsu

---
 rtl/warp_lsu.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/warp_lsu.sv
// warp_lsu: per-warp load/store unit. A memory instruction is captured on a
// start pulse and then serviced one enabled lane at a time, in ascending lane
// order, over a single valid/ready request channel with a response channel.
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to skip lanes whose address
// has bits [1:0] != 0 and raise the sticky misalign_err flag.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   enable, start         warp enable, one-cycle instruction request
//   thread_enable         per-lane execution mask
//   decoded_mem_read_enable / decoded_mem_write_enable   load / store select
//   rs1, rs2              per-lane address / store data
//   mem_req_*             request channel (valid, ready, we, addr, wdata)
//   mem_rsp_valid/_data   response channel
//   lsu_out               per-lane load results
//   busy, done            not idle / one-cycle completion pulse
//   misalign_err          sticky alignment error (0 unless feature enabled)
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module warp_lsu #(
   parameter int unsigned THREADS_PER_WARP = 32,
   parameter int unsigned DATA_WIDTH       = `DATA_WIDTH
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         enable,
   input  logic                                         start,
   input  logic [THREADS_PER_WARP-1:0]                  thread_enable,
   input  logic                                         decoded_mem_read_enable,
   input  logic                                         decoded_mem_write_enable,
   input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]  rs1,
   input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]  rs2,
   output logic                                         mem_req_valid,
   output logic                                         mem_req_we,
   output logic [DATA_WIDTH-1:0]                        mem_req_addr,
   output logic [DATA_WIDTH-1:0]                        mem_req_wdata,
   input  logic                                         mem_req_ready,
   input  logic                                         mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]                        mem_rsp_data,
   output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]  lsu_out,
   output logic                                         busy,
   output logic                                         done,
   output logic                                         misalign_err
);

   localparam int unsigned IDX_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

   typedef enum logic [1:0] {IDLE, REQUEST, WAIT, DONE} state_t;

   state_t state, state_next;

   logic [THREADS_PER_WARP-1:0]                 snap_mask;
   logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] snap_rs1;
   logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] snap_rs2;
   logic                                        snap_read;

   logic [IDX_W-1:0]            idx;
   logic [THREADS_PER_WARP-1:0] lane_bit;
   logic                        more_lanes;
   logic                        go;
   logic                        accept;
   logic [THREADS_PER_WARP-1:0] launch_mask;

   assign go     = start && enable && (decoded_mem_read_enable || decoded_mem_write_enable);
   assign accept = (state == IDLE) && go;

`ifdef LSU_MISALIGN_CHECK_EN
   // Misaligned lanes are dropped from the captured mask, so the lane walk
   // below never sees them.
   logic [THREADS_PER_WARP-1:0] bad_lanes;

   always_comb begin
      bad_lanes = '0;
      for (int unsigned i = 0; i < THREADS_PER_WARP; i++)
         bad_lanes[i] = (rs1[i][1:0] != 2'b00);
   end

   assign launch_mask = thread_enable & ~bad_lanes;

   always_ff @(posedge clk) begin
      if (reset)
         misalign_err <= 1'b0;
      else if (accept && |(thread_enable & bad_lanes))
         misalign_err <= 1'b1;
   end
`else
   assign launch_mask  = thread_enable;
   assign misalign_err = 1'b0;
`endif

   // Remaining-lane mask: the lowest set bit is the lane being serviced; its
   // bit is cleared when that lane's response arrives.
   always_comb begin
      idx = '0;
      for (int unsigned i = THREADS_PER_WARP; i > 0; i--)
         if (snap_mask[i-1]) idx = IDX_W'(i - 1);
      lane_bit      = '0;
      lane_bit[idx] = 1'b1;
      more_lanes    = |(snap_mask & ~lane_bit);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = state;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      busy          = 1'b1;
      done          = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (go) state_next = (launch_mask == '0) ? DONE : REQUEST;
         end
         REQUEST: begin
            mem_req_valid = 1'b1;
            mem_req_we    = ~snap_read;
            mem_req_addr  = snap_rs1[idx];
            mem_req_wdata = snap_rs2[idx];
            if (mem_req_ready) state_next = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid) state_next = more_lanes ? REQUEST : DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_mask <= '0;
         snap_rs1  <= '0;
         snap_rs2  <= '0;
         snap_read <= 1'b0;
         lsu_out   <= '0;
      end else begin
         if (accept) begin
            snap_mask <= launch_mask;
            snap_rs1  <= rs1;
            snap_rs2  <= rs2;
            snap_read <= decoded_mem_read_enable;
         end
         if (state == WAIT && mem_rsp_valid) begin
            snap_mask[idx] <= 1'b0;
            if (snap_read) lsu_out[idx] <= mem_rsp_data;
         end
      end
   end

endmodule
